control_fsm: RTL and testbench

Multi-cycle sequencing controller for the RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback using the decoder's classification flags. Drives the instruction-port and data-port handshakes, register-file and PC write enables, writeback and next-PC selects, and the trap path. Also counts retired instructions.

---
 rtl/core_pkg.sv | 57 +++++
 rtl/control_fsm_if.sv | 21 ++
 rtl/control_fsm_bus_watchdog.sv | 40 ++++
 rtl/control_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: sequencer states, datapath select
// encodings, trap causes and the decoder's opcode/immediate constants.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_ALU  = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_CSR  = 2'b11;

  localparam logic [2:0] TRAP_ILLEGAL = 3'd0;
  localparam logic [2:0] TRAP_IFETCH  = 3'd1;
  localparam logic [2:0] TRAP_DATA    = 3'd2;
  localparam logic [2:0] TRAP_ECALL   = 3'd3;
  localparam logic [2:0] TRAP_TIMEOUT = 3'd4;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_RS2 = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // Retired-instruction counter step; wraps naturally at 32 bits.
  function automatic logic [31:0] wrap_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction-port and data-port handshake bundle between the sequencer
// (master) and the bus side (slave). Suffixes are from the sequencer's view.
interface control_fsm_if;
  logic iport_stb_o;
  logic iport_ack_i;
  logic iport_err_i;
  logic dport_stb_o;
  logic dport_we_o;
  logic dport_ack_i;
  logic dport_err_i;

  modport master (
    output iport_stb_o, dport_stb_o, dport_we_o,
    input  iport_ack_i, iport_err_i, dport_ack_i, dport_err_i
  );

  modport slave (
    input  iport_stb_o, dport_stb_o, dport_we_o,
    output iport_ack_i, iport_err_i, dport_ack_i, dport_err_i
  );
endinterface

// File: rtl/control_fsm_bus_watchdog.sv
// Bus response watchdog: counts cycles spent waiting on a strobe and flags a
// timeout once the count reaches BUS_TIMEOUT. BUS_TIMEOUT = 0 disables it.
module bus_watchdog #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(BUS_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count while waiting; saturate at the limit so the flag stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (BUS_TIMEOUT != 0) && enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for the RV32I core.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// FETCH     | instruction strobe up, wait for ack/err/timeout
// DECODE    | one cycle, trap on illegal opcode
// EXECUTE   | one cycle, route to MEM, ecall/ebreak trap, or WRITEBACK
// MEM       | data strobe up, wait for ack/err/timeout
// WRITEBACK | one cycle, register/PC write, retire
// TRAP      | one cycle, PC to trap vector, cause already latched
//
// active_q keeps every strobe low during reset and the first cycle after
// release, so iport_stb_o rises one clock after rst_i deasserts.
module control_fsm
  import core_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  control_fsm_if.master       bus,
  input  logic                is_lui_i,
  input  logic                is_auipc_i,
  input  logic                is_jal_i,
  input  logic                is_jalr_i,
  input  logic                is_branch_i,
  input  logic                is_mem_i,
  input  logic                we_mem_i,
  input  logic                is_misc_mem_i,
  input  logic                is_system_i,
  input  logic [2:0]          funct3_i,
  input  logic [4:0]          rd_i,
  input  logic                illegal_i,
  input  logic                branch_taken_i,
  output logic                ir_we_o,
  output logic                rf_we_o,
  output logic                pc_we_o,
  output logic [1:0]          pc_sel_o,
  output logic [1:0]          wb_sel_o,
  output logic                trap_o,
  output logic [2:0]          trap_cause_o,
  output logic [31:0]         instret_o
);

  state_e      state_q, state_d;
  logic        active_q;
  logic [2:0]  trap_cause_q, trap_cause_d;
  logic [31:0] instret_q, instret_d;

  logic        wd_clear, wd_enable, wd_timeout;
  logic        is_store, is_load, is_csr, is_ecall;
  logic        wb_rf_we;
  logic [1:0]  wb_pc_sel, wb_wb_sel;
  logic        unused_flags;

  // LUI/AUIPC write back through the ALU path like any other ALU op.
  assign unused_flags = is_lui_i ^ is_auipc_i;

  assign wd_enable = (state_q == ST_FETCH && active_q) || (state_q == ST_MEM);
  assign wd_clear  = (state_d != state_q) &&
                     (state_d == ST_FETCH || state_d == ST_MEM);

  bus_watchdog #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .timeout_o (wd_timeout)
  );

  // Instruction classification used by EXECUTE and WRITEBACK.
  always_comb begin
    is_store  = is_mem_i & we_mem_i;
    is_load   = is_mem_i & ~we_mem_i;
    is_csr    = is_system_i & (funct3_i != 3'b000);
    is_ecall  = is_system_i & (funct3_i == 3'b000);
    wb_rf_we  = ~(is_branch_i | is_store | is_misc_mem_i) & (rd_i != 5'd0);
    wb_pc_sel = (is_jal_i | is_jalr_i | (is_branch_i & branch_taken_i)) ?
                PC_SEL_ALU : PC_SEL_PC4;
    if (is_jal_i || is_jalr_i) begin
      wb_wb_sel = WB_SEL_PC4;
    end else if (is_load) begin
      wb_wb_sel = WB_SEL_LOAD;
    end else if (is_csr) begin
      wb_wb_sel = WB_SEL_CSR;
    end else begin
      wb_wb_sel = WB_SEL_ALU;
    end
  end

  // Next-state, trap cause and retire count. Within a wait state err beats
  // ack, and ack beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    instret_d    = instret_q;
    case (state_q)
      ST_FETCH: begin
        if (active_q) begin
          if (bus.iport_err_i) begin
            state_d      = ST_TRAP;
            trap_cause_d = TRAP_IFETCH;
          end else if (bus.iport_ack_i) begin
            state_d = ST_DECODE;
          end else if (wd_timeout) begin
            state_d      = ST_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        if (illegal_i) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_mem_i) begin
          state_d = ST_MEM;
        end else if (is_ecall) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ECALL;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (bus.dport_err_i) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_DATA;
        end else if (bus.dport_ack_i) begin
          state_d = ST_WRITEBACK;
        end else if (wd_timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        state_d   = ST_FETCH;
        instret_d = wrap_inc(instret_q);
      end
      ST_TRAP: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Sequencer state, latched trap cause and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_FETCH;
      active_q     <= 1'b0;
      trap_cause_q <= TRAP_ILLEGAL;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
    end
  end

  // Handshake and datapath controls decoded from the current state.
  always_comb begin
    bus.iport_stb_o = 1'b0;
    bus.dport_stb_o = 1'b0;
    bus.dport_we_o  = 1'b0;
    ir_we_o         = 1'b0;
    rf_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    pc_sel_o        = PC_SEL_PC4;
    wb_sel_o        = WB_SEL_ALU;
    trap_o          = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.iport_stb_o = active_q;
        ir_we_o         = active_q & bus.iport_ack_i & ~bus.iport_err_i;
      end
      ST_MEM: begin
        bus.dport_stb_o = 1'b1;
        bus.dport_we_o  = we_mem_i;
      end
      ST_WRITEBACK: begin
        pc_we_o  = 1'b1;
        rf_we_o  = wb_rf_we;
        pc_sel_o = wb_pc_sel;
        wb_sel_o = wb_wb_sel;
      end
      ST_TRAP: begin
        trap_o   = 1'b1;
        pc_we_o  = 1'b1;
        pc_sel_o = PC_SEL_TRAP;
      end
      default: begin
      end
    endcase
  end

  assign trap_cause_o = trap_cause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: each instruction is described at the
// level of "what kind, how long the buses stall, whether they fault", and a
// small model predicts cycle count, strobe lengths, writeback controls, trap
// cause and retire count from the sequencing rules.
module tb_control_fsm;

  localparam int TO = 4;

  typedef enum logic [3:0] {
    K_ALU, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR,
    K_LOAD, K_STORE, K_FENCE, K_CSR, K_ECALL, K_ILL
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [4:0] rd;
    logic       taken;
    logic [3:0] iwait;
    logic       ierr;
    logic [3:0] dwait;
    logic       derr;
  } instr_t;

  typedef struct packed {
    logic [7:0]  cycles;
    logic [7:0]  istb;
    logic [7:0]  dstb;
    logic [7:0]  dwe;
    logic [7:0]  irwe;
    logic [7:0]  rfwe;
    logic [7:0]  trap;
    logic [2:0]  cause;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
  } obs_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic is_lui_i, is_auipc_i, is_jal_i, is_jalr_i, is_branch_i, is_mem_i;
  logic we_mem_i, is_misc_mem_i, is_system_i, illegal_i, branch_taken_i;
  logic [2:0] funct3_i;
  logic [4:0] rd_i;
  logic ir_we_o, rf_we_o, pc_we_o, trap_o;
  logic [1:0] pc_sel_o, wb_sel_o;
  logic [2:0] trap_cause_o;
  logic [31:0] instret_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_instret = '0;
  logic [2:0]  m_cause   = 3'd0;

  control_fsm_if bus ();

  control_fsm #(.BUS_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .is_lui_i(is_lui_i), .is_auipc_i(is_auipc_i), .is_jal_i(is_jal_i),
    .is_jalr_i(is_jalr_i), .is_branch_i(is_branch_i), .is_mem_i(is_mem_i),
    .we_mem_i(we_mem_i), .is_misc_mem_i(is_misc_mem_i), .is_system_i(is_system_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .illegal_i(illegal_i),
    .branch_taken_i(branch_taken_i), .ir_we_o(ir_we_o), .rf_we_o(rf_we_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .wb_sel_o(wb_sel_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  function automatic instr_t mk(input kind_e k, input int rd, input bit tk,
                                input int iw, input bit ie, input int dw, input bit de);
    instr_t r;
    r.kind = k; r.rd = 5'(rd); r.taken = tk;
    r.iwait = 4'(iw); r.ierr = ie; r.dwait = 4'(dw); r.derr = de;
    return r;
  endfunction

  // Expected observation from the sequencing rules: fetch takes
  // min(wait, TO)+1 strobe cycles, decode and execute one each, a memory
  // access likewise, then one writeback or trap cycle.
  function automatic obs_t model(input instr_t ins, input logic [31:0] ir, input logic [2:0] lc);
    obs_t e;
    int fc, dc;
    bit fok, dok, mem, retire, trap;
    e = '0; retire = 0; trap = 0;
    e.cause = lc;
    fok = int'(ins.iwait) <= TO;
    fc  = (fok ? int'(ins.iwait) : TO) + 1;
    e.istb = 8'(fc);
    mem = (ins.kind == K_LOAD) || (ins.kind == K_STORE);
    if (!fok) begin
      e.cycles = 8'(fc + 1); trap = 1; e.cause = 3'd4;
    end else if (ins.ierr) begin
      e.cycles = 8'(fc + 1); trap = 1; e.cause = 3'd1;
    end else begin
      e.irwe = 8'd1;
      if (ins.kind == K_ILL) begin
        e.cycles = 8'(fc + 2); trap = 1; e.cause = 3'd0;
      end else if (ins.kind == K_ECALL) begin
        e.cycles = 8'(fc + 3); trap = 1; e.cause = 3'd3;
      end else if (mem) begin
        dok = int'(ins.dwait) <= TO;
        dc  = (dok ? int'(ins.dwait) : TO) + 1;
        e.dstb   = 8'(dc);
        e.dwe    = (ins.kind == K_STORE) ? 8'(dc) : 8'd0;
        e.cycles = 8'(fc + 3 + dc);
        if (!dok) begin
          trap = 1; e.cause = 3'd4;
        end else if (ins.derr) begin
          trap = 1; e.cause = 3'd2;
        end else begin
          retire = 1;
        end
      end else begin
        e.cycles = 8'(fc + 3); retire = 1;
      end
    end
    e.instret = ir;
    if (trap) begin
      e.trap = 8'd1; e.pc_sel = 2'b10;
    end
    if (retire) begin
      e.instret = ir + 32'd1;
      if (!(ins.kind inside {K_BR, K_STORE, K_FENCE}) && ins.rd != 5'd0) e.rfwe = 8'd1;
      if (ins.kind inside {K_JAL, K_JALR} || (ins.kind == K_BR && ins.taken)) e.pc_sel = 2'b01;
      if (ins.kind inside {K_JAL, K_JALR}) e.wb_sel = 2'b10;
      else if (ins.kind == K_LOAD) e.wb_sel = 2'b01;
      else if (ins.kind == K_CSR) e.wb_sel = 2'b11;
    end
    return e;
  endfunction

  task automatic drive_flags(input instr_t ins);
    is_lui_i = 0; is_auipc_i = 0; is_jal_i = 0; is_jalr_i = 0; is_branch_i = 0;
    is_mem_i = 0; we_mem_i = 0; is_misc_mem_i = 0; is_system_i = 0; illegal_i = 0;
    funct3_i = 3'($urandom); rd_i = ins.rd; branch_taken_i = ins.taken;
    case (ins.kind)
      K_LUI:   is_lui_i = 1;
      K_AUIPC: is_auipc_i = 1;
      K_JAL:   is_jal_i = 1;
      K_JALR:  is_jalr_i = 1;
      K_BR:    is_branch_i = 1;
      K_LOAD:  is_mem_i = 1;
      K_STORE: begin is_mem_i = 1; we_mem_i = 1; end
      K_FENCE: is_misc_mem_i = 1;
      K_CSR:   begin is_system_i = 1; funct3_i = 3'($urandom_range(1, 7)); end
      K_ECALL: begin is_system_i = 1; funct3_i = 3'd0; end
      K_ILL:   illegal_i = 1;
      default: ;
    endcase
  endtask

  task automatic clear_resp();
    bus.iport_ack_i = 0; bus.iport_err_i = 0; bus.dport_ack_i = 0; bus.dport_err_i = 0;
  endtask

  // Runs one instruction from a fresh FETCH cycle; returns after the edge
  // that leaves WRITEBACK/TRAP. Stray responses are injected whenever the
  // matching strobe is low.
  task automatic run_instr(input instr_t ins, output obs_t o);
    bit done;
    o = '0; done = 0;
    drive_flags(ins);
    for (int g = 0; g < 64 && !done; g++) begin
      @(negedge clk_i);
      o.cycles = o.cycles + 8'd1;
      if (bus.iport_stb_o) begin
        o.istb = o.istb + 8'd1;
        bus.iport_ack_i = 0; bus.iport_err_i = 0;
        if (int'(ins.iwait) <= TO && int'(o.istb) == int'(ins.iwait) + 1) begin
          bus.iport_ack_i = 1; bus.iport_err_i = ins.ierr;
        end
      end else begin
        bus.iport_ack_i = 1'($urandom); bus.iport_err_i = 1'($urandom);
      end
      if (bus.dport_stb_o) begin
        o.dstb = o.dstb + 8'd1;
        bus.dport_ack_i = 0; bus.dport_err_i = 0;
        if (int'(ins.dwait) <= TO && int'(o.dstb) == int'(ins.dwait) + 1) begin
          bus.dport_ack_i = 1; bus.dport_err_i = ins.derr;
        end
      end else begin
        bus.dport_ack_i = 1'($urandom); bus.dport_err_i = 1'($urandom);
      end
      #1;
      if (ir_we_o) o.irwe = o.irwe + 8'd1;
      if (bus.dport_we_o) o.dwe = o.dwe + 8'd1;
      if (rf_we_o) o.rfwe = o.rfwe + 8'd1;
      if (trap_o) o.trap = o.trap + 8'd1;
      if (pc_we_o) begin
        done = 1;
        o.pc_sel = pc_sel_o;
        o.wb_sel = trap_o ? 2'b00 : wb_sel_o;
        o.cause  = trap_cause_o;
      end
    end
    @(posedge clk_i); #1;
    o.instret = instret_o;
    clear_resp();
  endtask

  task automatic test_reset();
    bus.iport_ack_i = 1; bus.iport_err_i = 0; bus.dport_ack_i = 1; bus.dport_err_i = 0;
    drive_flags(mk(K_ALU, 1, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk_i);
    n_checks++; if (bus.iport_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_iport_stb: got %b expected 0", bus.iport_stb_o); end
    n_checks++; if (bus.dport_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_dport_stb: got %b expected 0", bus.dport_stb_o); end
    n_checks++; if (ir_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_ir_we: got %b expected 0", ir_we_o); end
    n_checks++; if ({rf_we_o, pc_we_o, trap_o} !== 3'b000) begin n_fail++; $display("FAIL reset_we_trap: got %b expected 000", {rf_we_o, pc_we_o, trap_o}); end
    n_checks++; if (trap_cause_o !== 3'd0) begin n_fail++; $display("FAIL reset_trap_cause: got %0d expected 0", trap_cause_o); end
    n_checks++; if (instret_o !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret_o); end
    rst_i = 1; clear_resp();
    @(posedge clk_i); #1;
    n_checks++; if (bus.iport_stb_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_stb: got %b expected 1", bus.iport_stb_o); end
  endtask

  task automatic test_directed();
    instr_t list [14];
    obs_t o, e;
    list[0]  = mk(K_ALU,   1, 0, 0, 0, 0, 0);
    list[1]  = mk(K_LOAD,  3, 0, 0, 0, 2, 0);
    list[2]  = mk(K_STORE, 7, 0, 0, 0, 0, 0);
    list[3]  = mk(K_BR,    9, 1, 0, 0, 0, 0);
    list[4]  = mk(K_JAL,   0, 0, 0, 0, 0, 0);
    list[5]  = mk(K_ECALL, 0, 0, 0, 0, 0, 0);
    list[6]  = mk(K_LOAD,  4, 0, 0, 0, 5, 0);
    list[7]  = mk(K_LOAD,  4, 0, 0, 0, 1, 1);
    list[8]  = mk(K_ALU,   6, 0, 4, 0, 0, 0);
    list[9]  = mk(K_CSR,   2, 0, 1, 0, 0, 0);
    list[10] = mk(K_ALU,   2, 0, 2, 1, 0, 0);
    list[11] = mk(K_JALR,  5, 0, 0, 0, 0, 0);
    list[12] = mk(K_FENCE, 3, 0, 0, 0, 0, 0);
    list[13] = mk(K_ILL,   3, 0, 0, 0, 0, 0);
    foreach (list[i]) begin
      e = model(list[i], m_instret, m_cause);
      run_instr(list[i], o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL directed_%0d (%s): got %p expected %p", i, list[i].kind.name(), o, e);
      end
      m_instret = e.instret; m_cause = e.cause;
    end
  endtask

  task automatic test_random();
    instr_t ins;
    obs_t o, e;
    for (int i = 0; i < 60; i++) begin
      ins.kind  = kind_e'($urandom_range(0, 11));
      ins.rd    = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      ins.taken = 1'($urandom);
      ins.iwait = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 5) : 0);
      ins.ierr  = ($urandom_range(0, 9) == 0);
      ins.dwait = 4'($urandom_range(0, 5));
      ins.derr  = ($urandom_range(0, 7) == 0);
      e = model(ins, m_instret, m_cause);
      run_instr(ins, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_%0d (%s): got %p expected %p", i, ins.kind.name(), o, e);
      end
      m_instret = e.instret; m_cause = e.cause;
    end
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    seen = 0;
    drive_flags(mk(K_LOAD, 8, 0, 0, 0, 0, 0));
    for (int g = 0; g < 16 && !seen; g++) begin
      @(negedge clk_i);
      bus.iport_ack_i = bus.iport_stb_o; bus.iport_err_i = 0;
      bus.dport_ack_i = 0; bus.dport_err_i = 0;
      seen = bus.dport_stb_o;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midmem_reach: got no dport_stb expected dport_stb within 16 cycles"); end
    rst_i = 0; bus.dport_ack_i = 1;
    #1;
    n_checks++; if ({bus.dport_stb_o, bus.iport_stb_o} !== 2'b00) begin n_fail++; $display("FAIL midmem_strobes: got %b expected 00", {bus.dport_stb_o, bus.iport_stb_o}); end
    n_checks++; if ({rf_we_o, pc_we_o} !== 2'b00) begin n_fail++; $display("FAIL midmem_we: got %b expected 00", {rf_we_o, pc_we_o}); end
    n_checks++; if (instret_o !== 32'd0) begin n_fail++; $display("FAIL midmem_instret: got %0d expected 0", instret_o); end
    @(negedge clk_i);
    rst_i = 1; clear_resp();
    @(posedge clk_i); #1;
    n_checks++; if (bus.iport_stb_o !== 1'b1) begin n_fail++; $display("FAIL midmem_release_stb: got %b expected 1", bus.iport_stb_o); end
    n_checks++; if (instret_o !== 32'd0) begin n_fail++; $display("FAIL midmem_release_instret: got %0d expected 0", instret_o); end
    m_instret = '0; m_cause = 3'd0;
  endtask

  task automatic test_instret_wrap();
    obs_t o, e;
    instr_t ins;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    n_checks++; if (instret_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffffffff", instret_o); end
    ins = mk(K_ALU, 5, 0, 0, 0, 0, 0);
    e = model(ins, m_instret, m_cause);
    run_instr(ins, o);
    n_checks++; if (o !== e) begin n_fail++; $display("FAIL wrap_retire: got %p expected %p", o, e); end
    m_instret = e.instret;
    ins = mk(K_JAL, 4, 0, 1, 0, 0, 0);
    e = model(ins, m_instret, m_cause);
    run_instr(ins, o);
    n_checks++; if (o !== e) begin n_fail++; $display("FAIL wrap_next: got %p expected %p", o, e); end
    m_instret = e.instret;
  endtask

  initial begin
    clear_resp();
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
